multimode_ring_counter: RTL and testbench

MULTIMODE_RING_COUNTER -- requirements
Module: multimode_ring_counter

---
 rtl/ring_counter_pkg.sv | 10 +
 rtl/ring_next_state.sv | 43 ++++
 rtl/multimode_ring_counter.sv | 68 ++++++
 tb/tb_multimode_ring_counter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// rtl/ring_counter_pkg.sv - shared mode encodings and home value for the multimode ring counter
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // Home is bit 0 set; callers slice this to their own width.
  localparam logic [31:0] HOME_VALUE = 32'd1;

endpackage

// File: rtl/ring_next_state.sv
// rtl/ring_next_state.sv - combinational next-state and legality for ring/Johnson counting
module ring_next_state
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] next,
  output logic             cur_legal,
  output logic             load_legal
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Johnson states are LSB-filled thermometers or their complements;
  // v & (v+1) == 0 exactly when v is all ones from bit 0 upward (incl. zero).
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    logic [WIDTH-1:0] nv;
    nv = ~v;
    if (m == MODE_RING) begin
      return $onehot(v);
    end
    return ((v & (v + ONE)) == '0) || ((nv & (nv + ONE)) == '0);
  endfunction

  always_comb begin
    next = cur;
    if (mode == MODE_RING) begin
      if (dir) next = {cur[WIDTH-2:0], cur[WIDTH-1]};
      else     next = {cur[0], cur[WIDTH-1:1]};
    end else begin
      if (dir) next = {cur[WIDTH-2:0], ~cur[WIDTH-1]};
      else     next = {~cur[0], cur[WIDTH-1:1]};
    end
  end

  assign cur_legal  = is_legal(cur, mode);
  assign load_legal = is_legal(load_val, mode);

endmodule

// File: rtl/multimode_ring_counter.sv
// rtl/multimode_ring_counter.sv - ring/Johnson counter with load, illegal-state recovery and wrap/err pulses
module multimode_ring_counter
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] HOME = HOME_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;
  logic             r_err;
  logic [WIDTH-1:0] w_next;
  logic             w_cur_legal;
  logic             w_load_legal;

  ring_next_state #(.WIDTH(WIDTH)) u_next (
    .cur        (r_out),
    .load_val   (load_val),
    .mode       (mode),
    .dir        (dir),
    .next       (w_next),
    .cur_legal  (w_cur_legal),
    .load_legal (w_load_legal)
  );

  // Priority: reset, load, recovery of an illegal state, step, hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= HOME;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (load) begin
        if (w_load_legal) begin
          r_out <= load_val;
        end else begin
          r_out <= HOME;
          r_err <= 1'b1;
        end
      end else if (!w_cur_legal) begin
        r_out <= HOME;
        r_err <= 1'b1;
      end else if (en) begin
        r_out  <= w_next;
        r_wrap <= (w_next == HOME);
      end
    end
  end

  assign out  = r_out;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule

// File: tb/tb_multimode_ring_counter.sv
// tb/tb_multimode_ring_counter.sv - vector table and scoreboard bench for multimode_ring_counter
module tb_multimode_ring_counter;

  localparam int WIDTH = 4;

  typedef struct {
    string            name;
    logic             rst;
    logic             en;
    logic             dir;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] exp_out;
    logic             exp_wrap;
    logic             exp_err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             dir = 1'b0;
  logic             mode = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] out;
  logic             wrap;
  logic             err;

  int checks = 0;
  int failures = 0;

  vec_t tbl[$];
  vec_t sb[$];

  multimode_ring_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(string nm, logic r, logic e, logic d, logic m, logic l,
                              logic [WIDTH-1:0] lv, logic [WIDTH-1:0] eo, logic ew, logic ee);
    vec_t v;
    v.name = nm; v.rst = r; v.en = e; v.dir = d; v.mode = m; v.load = l;
    v.load_val = lv; v.exp_out = eo; v.exp_wrap = ew; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; en = v.en; dir = v.dir; mode = v.mode; load = v.load; load_val = v.load_val;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s actual=empty required=entry", v.name);
    end else begin
      e = sb.pop_front();
      check({e.name, ".out"}, 32'(out), 32'(e.exp_out));
      check({e.name, ".wrap"}, 32'(wrap), 32'(e.exp_wrap));
      check({e.name, ".err"}, 32'(err), 32'(e.exp_err));
      check({e.name, ".excl"}, 32'(wrap & err), 32'd0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] jdn[8];

    // Columns: name, rst, en, dir, mode, load, load_val | out, wrap, err
    tbl.push_back(mk("reset",       1,0,0,0,0,4'h0, 4'b0001,0,0));
    tbl.push_back(mk("ring_up1",    0,1,1,0,0,4'h0, 4'b0010,0,0));
    tbl.push_back(mk("ring_up2",    0,1,1,0,0,4'h0, 4'b0100,0,0));
    tbl.push_back(mk("ring_up3",    0,1,1,0,0,4'h0, 4'b1000,0,0));
    tbl.push_back(mk("ring_up4",    0,1,1,0,0,4'h0, 4'b0001,1,0));
    tbl.push_back(mk("ring_hold",   0,0,1,0,0,4'h0, 4'b0001,0,0));
    tbl.push_back(mk("j_reset",     1,0,1,1,0,4'h0, 4'b0001,0,0));
    tbl.push_back(mk("j_up1",       0,1,1,1,0,4'h0, 4'b0011,0,0));
    tbl.push_back(mk("j_up2",       0,1,1,1,0,4'h0, 4'b0111,0,0));
    tbl.push_back(mk("j_up3",       0,1,1,1,0,4'h0, 4'b1111,0,0));
    tbl.push_back(mk("j_up4",       0,1,1,1,0,4'h0, 4'b1110,0,0));
    tbl.push_back(mk("j_up5",       0,1,1,1,0,4'h0, 4'b1100,0,0));
    tbl.push_back(mk("j_up6",       0,1,1,1,0,4'h0, 4'b1000,0,0));
    tbl.push_back(mk("j_up7",       0,1,1,1,0,4'h0, 4'b0000,0,0));
    tbl.push_back(mk("j_up8",       0,1,1,1,0,4'h0, 4'b0001,1,0));
    tbl.push_back(mk("rd_reset",    1,0,0,0,0,4'h0, 4'b0001,0,0));
    tbl.push_back(mk("ring_dn1",    0,1,0,0,0,4'h0, 4'b1000,0,0));
    tbl.push_back(mk("ring_dn2",    0,1,0,0,0,4'h0, 4'b0100,0,0));
    tbl.push_back(mk("ring_dn3",    0,1,0,0,0,4'h0, 4'b0010,0,0));
    tbl.push_back(mk("ring_dn4",    0,1,0,0,0,4'h0, 4'b0001,1,0));
    tbl.push_back(mk("load_bad",    0,0,1,0,1,4'b0110, 4'b0001,0,1));
    tbl.push_back(mk("load_bad_cl", 0,0,1,0,0,4'h0, 4'b0001,0,0));
    tbl.push_back(mk("load_ok",     0,0,1,0,1,4'b0100, 4'b0100,0,0));
    tbl.push_back(mk("mid_step",    0,1,1,0,0,4'h0, 4'b1000,0,0));
    tbl.push_back(mk("rst_vs_load", 1,1,1,0,1,4'b1000, 4'b0001,0,0));
    tbl.push_back(mk("post_rst",    0,1,1,0,0,4'h0, 4'b0010,0,0));
    tbl.push_back(mk("load_vs_en",  0,1,1,0,1,4'b1000, 4'b1000,0,0));
    tbl.push_back(mk("load_home",   0,1,1,0,1,4'b0001, 4'b0001,0,0));
    tbl.push_back(mk("jload_ok",    0,0,1,1,1,4'b1110, 4'b1110,0,0));
    tbl.push_back(mk("jload_bad",   0,0,1,1,1,4'b0101, 4'b0001,0,1));
    tbl.push_back(mk("jload_ok2",   0,0,1,1,1,4'b1110, 4'b1110,0,0));
    tbl.push_back(mk("recov_en",    0,1,1,0,0,4'h0, 4'b0001,0,1));
    tbl.push_back(mk("recov_after", 0,1,1,0,0,4'h0, 4'b0010,0,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Johnson to ring switch while idle at 0011.
    apply(mk("sw_reset", 1,0,1,1,0,4'h0, 4'b0001,0,0));
    apply(mk("sw_step",  0,1,1,1,0,4'h0, 4'b0011,0,0));
    apply(mk("sw_mode",  0,0,1,0,0,4'h0, 4'b0001,0,1));
    apply(mk("sw_clear", 0,0,1,0,0,4'h0, 4'b0001,0,0));

    // Direction change takes effect on the very next step.
    apply(mk("dc_up",   0,1,1,0,0,4'h0, 4'b0010,0,0));
    apply(mk("dc_down", 0,1,0,0,0,4'h0, 4'b0001,1,0));
    apply(mk("dc_up2",  0,1,1,0,0,4'h0, 4'b0010,0,0));

    // Johnson down: full 8-step period from home, wrap only on the last step.
    jdn = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
    apply(mk("jd_reset", 1,0,0,1,0,4'h0, 4'b0001,0,0));
    for (int k = 0; k < 8; k++) begin
      apply(mk($sformatf("jd_step%0d", k + 1), 0,1,0,1,0,4'h0, jdn[k], (k == 7), 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
